// File: rtl/int_wb_arbiter_pkg.sv
// Shared widths, source indices and the per-source writeback holding entry
// for the integer writeback arbiter.
package int_wb_arbiter_pkg;

  localparam int NUM_SRC = 4;
  localparam int ADDR_W  = 5;
  localparam int DATA_W  = 64;

  localparam int SRC_ALU = 0;
  localparam int SRC_MUL = 1;
  localparam int SRC_DIV = 2;
  localparam int SRC_MEM = 3;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_rr_arbiter.sv
// Combinational round-robin selector: the lowest offset from rr_ptr with a
// pending request wins, producing a one-hot grant.
module wb_rr_arbiter #(
  parameter int N     = int_wb_arbiter_pkg::NUM_SRC,
  parameter int PTR_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] rr_ptr,
  output logic [N-1:0]     gnt
);

  logic [PTR_W-1:0] idx;

  // Scan from the farthest offset down so the nearest requester overwrites last.
  always_comb begin
    gnt = '0;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      idx = PTR_W'((int'(rr_ptr) + i) % N);
      if (req[idx]) begin
        gnt      = '0;
        gnt[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/int_wb_arbiter.sv
// Integer writeback arbiter: one holding entry per result source, round-robin
// grant into a single registered register-file write port.
module int_wb_arbiter #(
  parameter int NUM_SRC = int_wb_arbiter_pkg::NUM_SRC,
  parameter int ADDR_W  = int_wb_arbiter_pkg::ADDR_W,
  parameter int DATA_W  = int_wb_arbiter_pkg::DATA_W
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      lock,
  input  logic [NUM_SRC-1:0]        src_valid,
  output logic [NUM_SRC-1:0]        src_ready,
  input  logic [NUM_SRC*ADDR_W-1:0] src_addr,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  output logic                      write_enable1,
  output logic [ADDR_W-1:0]         write_addr1,
  output logic [DATA_W-1:0]         write_data1,
  output logic                      commit_valid,
  output logic [1:0]                commit_src
);
  import int_wb_arbiter_pkg::*;

  localparam int PTR_W = $clog2(NUM_SRC);

  wb_entry_t [NUM_SRC-1:0] ent;
  wb_entry_t               gnt_ent;
  logic [NUM_SRC-1:0]      req, gnt;
  logic [PTR_W-1:0]        rr_ptr, gnt_idx;
  logic                    any_gnt;

  always_comb begin
    req = '0;
    for (int k = 0; k < NUM_SRC; k++) req[k] = ent[k].valid & ~lock;
  end

  wb_rr_arbiter #(.N(NUM_SRC), .PTR_W(PTR_W)) u_rr (
    .req    (req),
    .rr_ptr (rr_ptr),
    .gnt    (gnt)
  );

  always_comb begin
    gnt_idx = '0;
    for (int k = 0; k < NUM_SRC; k++)
      if (gnt[k]) gnt_idx = PTR_W'(k);
    any_gnt = |gnt;
    gnt_ent = ent[gnt_idx];
  end

  // An entry being drained this cycle can take a new result with no bubble.
  always_comb begin
    src_ready = '0;
    for (int k = 0; k < NUM_SRC; k++)
      src_ready[k] = ~RST & (~ent[k].valid | gnt[k]);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ent <= '0;
    end else begin
      for (int k = 0; k < NUM_SRC; k++) begin
        if (src_valid[k] && src_ready[k])
          ent[k] <= '{valid: 1'b1,
                      addr:  src_addr[k*ADDR_W +: ADDR_W],
                      data:  src_data[k*DATA_W +: DATA_W]};
        else if (gnt[k])
          ent[k].valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rr_ptr        <= '0;
      commit_valid  <= 1'b0;
      commit_src    <= '0;
      write_enable1 <= 1'b0;
      write_addr1   <= '0;
      write_data1   <= '0;
    end else begin
      commit_valid  <= any_gnt;
      // x0 writes still retire, they just never reach the register file.
      write_enable1 <= any_gnt && (gnt_ent.addr != '0);
      if (any_gnt) begin
        rr_ptr      <= PTR_W'((int'(gnt_idx) + 1) % NUM_SRC);
        commit_src  <= 2'(gnt_idx);
        write_addr1 <= gnt_ent.addr;
        write_data1 <= gnt_ent.data;
      end
    end
  end

endmodule

// File: tb/tb_int_wb_arbiter.sv
// Self-checking bench for int_wb_arbiter: directed scenarios plus a random
// run, all compared against a behavioural model of entries and rr pointer.
module tb_int_wb_arbiter;
  localparam int NS = 4;
  localparam int AW = 5;
  localparam int DW = 64;

  logic              CLK = 1'b0;
  logic              RST = 1'b1;
  logic              lock = 1'b0;
  logic [NS-1:0]     src_valid = '0;
  logic [NS-1:0]     src_ready;
  logic [NS*AW-1:0]  src_addr = '0;
  logic [NS*DW-1:0]  src_data = '0;
  logic              write_enable1;
  logic [AW-1:0]     write_addr1;
  logic [DW-1:0]     write_data1;
  logic              commit_valid;
  logic [1:0]        commit_src;

  int checks = 0;
  int errors = 0;

  int_wb_arbiter dut (
    .CLK(CLK), .RST(RST), .lock(lock),
    .src_valid(src_valid), .src_ready(src_ready),
    .src_addr(src_addr), .src_data(src_data),
    .write_enable1(write_enable1), .write_addr1(write_addr1),
    .write_data1(write_data1), .commit_valid(commit_valid),
    .commit_src(commit_src)
  );

  always #5 CLK = ~CLK;

  // commit_src only carries meaning when a commit is reported
  logic [72:0] dut_out;
  assign dut_out = {commit_valid, write_enable1, write_addr1, write_data1,
                    commit_valid ? commit_src : 2'b00};

  // ---------------- reference model ----------------
  bit          mv[NS];
  logic [AW-1:0] ma[NS];
  logic [DW-1:0] md[NS];
  int          mptr;
  bit          m_cv, m_we;
  int          m_cs;
  logic [AW-1:0] m_wa;
  logic [DW-1:0] m_wd;

  function automatic int m_pick();
    if (RST || lock) return -1;
    for (int i = 0; i < NS; i++) begin
      int k = (mptr + i) % NS;
      if (mv[k]) return k;
    end
    return -1;
  endfunction

  function automatic logic [NS-1:0] m_ready();
    logic [NS-1:0] r = '0;
    int g = m_pick();
    if (RST) return '0;
    for (int k = 0; k < NS; k++) r[k] = !mv[k] || (g == k);
    return r;
  endfunction

  function automatic logic [72:0] m_out();
    return {m_cv, m_we, m_wa, m_wd, m_cv ? 2'(m_cs) : 2'b00};
  endfunction

  task automatic m_clear();
    for (int k = 0; k < NS; k++) begin mv[k] = 0; ma[k] = '0; md[k] = '0; end
    mptr = 0; m_cv = 0; m_we = 0; m_cs = 0; m_wa = '0; m_wd = '0;
  endtask

  task automatic tick();
    int g = m_pick();
    logic [NS-1:0] r = m_ready();
    @(posedge CLK); #1;
    if (RST) m_clear();
    else begin
      m_cv = (g >= 0);
      m_we = 0;
      if (g >= 0) begin
        m_cs = g; m_wa = ma[g]; m_wd = md[g]; m_we = (ma[g] != 0);
        mptr = (g + 1) % NS; mv[g] = 0;
      end
      for (int k = 0; k < NS; k++)
        if (src_valid[k] && r[k]) begin
          mv[k] = 1; ma[k] = src_addr[k*AW +: AW]; md[k] = src_data[k*DW +: DW];
        end
    end
  endtask

  task automatic set_src(input int k, input bit v, input logic [AW-1:0] a, input logic [DW-1:0] d);
    src_valid[k] = v;
    src_addr[k*AW +: AW] = a;
    src_data[k*DW +: DW] = d;
  endtask

  task automatic clear_src();
    for (int k = 0; k < NS; k++) set_src(k, 0, '0, '0);
  endtask

  task automatic do_reset();
    clear_src(); lock = 0; RST = 1; m_clear();
    tick(); tick();
    RST = 0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    RST = 1; m_clear(); #3;
    checks++;
    if (dut_out !== 73'd0 || src_ready !== 4'b0000) begin
      errors++; $display("FAIL reset_async got out=%h rdy=%b exp out=0 rdy=0", dut_out, src_ready);
    end
    tick(); tick();
    checks++;
    if (dut_out !== m_out() || src_ready !== 4'b0000) begin
      errors++; $display("FAIL reset_held got out=%h rdy=%b exp out=%h rdy=0", dut_out, src_ready, m_out());
    end
    RST = 0; #1;
    checks++;
    if (src_ready !== 4'b1111) begin
      errors++; $display("FAIL reset_release_ready got %b exp 1111", src_ready);
    end
  endtask

  task automatic test_single_alu();
    do_reset();
    set_src(0, 1, 5'd5, 64'hA5); #1;
    checks++;
    if (src_ready[0] !== 1'b1) begin
      errors++; $display("FAIL alu_ready got %b exp 1", src_ready[0]);
    end
    tick();
    clear_src();
    checks++;
    if (commit_valid !== 1'b0) begin
      errors++; $display("FAIL alu_latency1 got cv=%b exp 0", commit_valid);
    end
    tick();
    checks++;
    if ({write_enable1, write_addr1, write_data1, commit_valid, commit_src} !==
        {1'b1, 5'd5, 64'hA5, 1'b1, 2'd0}) begin
      errors++; $display("FAIL alu_commit got we=%b a=%0d d=%h cv=%b cs=%0d exp we=1 a=5 d=a5 cv=1 cs=0",
                         write_enable1, write_addr1, write_data1, commit_valid, commit_src);
    end
    tick();
    checks++;
    if (dut_out !== m_out() || commit_valid !== 1'b0) begin
      errors++; $display("FAIL alu_idle got %h exp %h", dut_out, m_out());
    end
  endtask

  task automatic test_all_four();
    do_reset();
    for (int k = 0; k < NS; k++) set_src(k, 1, AW'(k + 1), {$urandom, $urandom});
    tick();
    clear_src();
    for (int i = 0; i < NS; i++) begin
      tick();
      checks++;
      if (commit_valid !== 1'b1 || commit_src !== 2'(i) || write_addr1 !== AW'(i + 1) || dut_out !== m_out()) begin
        errors++; $display("FAIL all_four_order[%0d] got cv=%b cs=%0d a=%0d exp cv=1 cs=%0d a=%0d",
                           i, commit_valid, commit_src, write_addr1, i, i + 1);
      end
    end
    tick();
    checks++;
    if (commit_valid !== 1'b0) begin
      errors++; $display("FAIL all_four_drain got cv=%b exp 0", commit_valid);
    end
    // pointer should be back at ALU: ALU beats MEM
    set_src(3, 1, 5'd9, 64'h3); set_src(0, 1, 5'd8, 64'h1);
    tick(); clear_src(); tick();
    checks++;
    if (commit_valid !== 1'b1 || commit_src !== 2'd0) begin
      errors++; $display("FAIL all_four_ptr_wrap got cv=%b cs=%0d exp cv=1 cs=0", commit_valid, commit_src);
    end
    tick();
    checks++;
    if (commit_src !== 2'd3 || dut_out !== m_out()) begin
      errors++; $display("FAIL all_four_mem_next got cs=%0d exp 3", commit_src);
    end
  endtask

  task automatic test_x0();
    do_reset();
    set_src(3, 1, 5'd0, 64'hDEAD_BEEF);
    tick(); clear_src(); tick();
    checks++;
    if (commit_valid !== 1'b1 || commit_src !== 2'd3 || write_enable1 !== 1'b0) begin
      errors++; $display("FAIL x0_suppress got cv=%b cs=%0d we=%b exp cv=1 cs=3 we=0",
                         commit_valid, commit_src, write_enable1);
    end
  endtask

  task automatic test_lock();
    do_reset();
    lock = 1;
    set_src(1, 1, 5'd7, 64'h77); set_src(2, 1, 5'd9, 64'h99); #1;
    checks++;
    if (src_ready[2:1] !== 2'b11) begin
      errors++; $display("FAIL lock_accept got %b exp 11", src_ready[2:1]);
    end
    tick(); clear_src();
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (commit_valid !== 1'b0 || write_enable1 !== 1'b0 || src_ready[1] !== 1'b0) begin
        errors++; $display("FAIL lock_hold[%0d] got cv=%b we=%b rdy1=%b exp 0 0 0",
                           i, commit_valid, write_enable1, src_ready[1]);
      end
    end
    lock = 0;
    tick();
    checks++;
    if (commit_valid !== 1'b1 || commit_src !== 2'd1 || write_addr1 !== 5'd7) begin
      errors++; $display("FAIL lock_release_mul got cv=%b cs=%0d a=%0d exp 1 1 7", commit_valid, commit_src, write_addr1);
    end
    tick();
    checks++;
    if (commit_valid !== 1'b1 || commit_src !== 2'd2 || write_data1 !== 64'h99) begin
      errors++; $display("FAIL lock_release_div got cv=%b cs=%0d d=%h exp 1 2 99", commit_valid, commit_src, write_data1);
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] dq[$];
    do_reset();
    for (int i = 0; i < 10; i++) begin
      logic [DW-1:0] d = {$urandom, $urandom};
      set_src(0, 1, AW'(i + 1), d);
      dq.push_back(d);
      #1;
      checks++;
      if (src_ready[0] !== 1'b1) begin
        errors++; $display("FAIL stream_ready[%0d] got %b exp 1", i, src_ready[0]);
      end
      tick();
      if (i >= 1) begin
        checks++;
        if (commit_valid !== 1'b1 || write_data1 !== dq[i-1] || dut_out !== m_out()) begin
          errors++; $display("FAIL stream_commit[%0d] got cv=%b d=%h exp cv=1 d=%h", i, commit_valid, write_data1, dq[i-1]);
        end
      end
    end
    clear_src();
    tick();
    checks++;
    if (commit_valid !== 1'b1 || write_data1 !== dq[9]) begin
      errors++; $display("FAIL stream_last got cv=%b d=%h exp cv=1 d=%h", commit_valid, write_data1, dq[9]);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int k = 0; k < 3; k++) set_src(k, 1, AW'(k + 3), {$urandom, $urandom});
    tick(); clear_src(); tick();
    #2; RST = 1; m_clear(); #1;
    checks++;
    if (dut_out !== 73'd0 || src_ready !== 4'b0000) begin
      errors++; $display("FAIL rst_mid_async got out=%h rdy=%b exp 0 0", dut_out, src_ready);
    end
    tick(); tick();
    RST = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (commit_valid !== 1'b0 || write_enable1 !== 1'b0 || dut_out !== m_out()) begin
        errors++; $display("FAIL rst_mid_discard[%0d] got cv=%b we=%b exp 0 0", i, commit_valid, write_enable1);
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 400; n++) begin
      lock = ($urandom_range(0, 4) == 0);
      for (int k = 0; k < NS; k++)
        set_src(k, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 31)), {$urandom, $urandom});
      #1;
      checks++;
      if (src_ready !== m_ready()) begin
        errors++; $display("FAIL rand_ready[%0d] got %b exp %b", n, src_ready, m_ready());
      end
      tick();
      checks++;
      if (dut_out !== m_out()) begin
        errors++; $display("FAIL rand_out[%0d] got %h exp %h", n, dut_out, m_out());
      end
    end
    clear_src(); lock = 0;
  endtask

  initial begin
    test_reset();
    test_single_alu();
    test_all_four();
    test_x0();
    test_lock();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running exp finished");
    $fatal(1);
  end

endmodule
